key_state_decoder: RTL and testbench

- Upstream neighbour of the character controller. Converts the PS/2 scan-code set 2 byte stream from the PS/2 receiver into held key levels `key_space`, `key_left` and `key_right`, which the controller samples directly.
- Tracks make/break and E0-extended prefixes with a small FSM. Times out stale prefixes and releases all keys on keyboard reset or hot-plug.
- Runs in the 100 MHz system clock domain; the rx strobe is already synchronous to `clk`.

---
 rtl/kbd_pkg.sv | 24 ++
 rtl/key_state_decoder_prefix_timeout.sv | 26 ++
 rtl/key_state_decoder.sv | 162 ++++++++++++++++
 tb/tb_key_state_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared scan-code constants and FSM state type for the PS/2 key decoding path.
package kbd_pkg;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_BAT_ERR = 8'hFC;
    localparam logic [7:0] SC_SPACE   = 8'h29;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_RIGHT   = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    // Keyboard self-test result (pass or fail) means the keyboard was reset or re-plugged.
    function automatic logic is_kbd_reset(input logic [7:0] code);
        return (code == SC_BAT_OK) || (code == SC_BAT_ERR);
    endfunction

endpackage

// File: rtl/key_state_decoder_prefix_timeout.sv
// Prefix gap counter: counts while a prefix is pending, pulses expire when the gap hits LIMIT.
module prefix_timeout #(
    parameter int unsigned LIMIT = 500_000,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != W'(LIMIT))) begin
            count <= count + W'(1);
        end
    end

    // Fires on the cycle whose increment would reach LIMIT, so the FSM leaves the prefix state on that edge.
    assign expire = en && !clr && (count == W'(LIMIT - 1));

endmodule

// File: rtl/key_state_decoder.sv
// PS/2 set-2 scan-code stream to held key levels for space, left and right.
// Optional macro KEY_LR_LAST_WINS_EN: when both arrows are held only the newer one is driven.
//
// state    | meaning
// ---------+-------------------------------------------
// IDLE     | no prefix pending
// EXT      | E0 seen, waiting for extended code or F0
// BRK      | F0 seen, waiting for break code
// EXT_BRK  | E0 F0 seen, waiting for extended break code
module key_state_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned CLK_FREQ          = 100_000_000,
    parameter int unsigned PREFIX_TIMEOUT_US = 5000,
    parameter logic [7:0]  SPACE_CODE        = SC_SPACE,
    parameter logic [7:0]  LEFT_CODE         = SC_LEFT,
    parameter logic [7:0]  RIGHT_CODE        = SC_RIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       key_space,
    output logic       key_left,
    output logic       key_right,
    output logic       key_event
);

    localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * PREFIX_TIMEOUT_US;

    kbd_state_t state, state_next;
    logic       held_space, held_left, held_right;
    logic       space_next, left_next, right_next;
    logic       vis_left, vis_right;
    logic       event_next;
    logic       tmo_clr, tmo_en, tmo_expire;

    assign tmo_en  = (state != ST_IDLE);
    assign tmo_clr = rx_valid || rx_err || (state == ST_IDLE);

    prefix_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_prefix_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_comb begin
        state_next = state;
        space_next = held_space;
        left_next  = held_left;
        right_next = held_right;

        if (rx_err) begin
            state_next = ST_IDLE;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_data == SC_BRK) begin
                        state_next = ST_BRK;
                    end else if (rx_data == SPACE_CODE) begin
                        space_next = 1'b1;
                    end else if (is_kbd_reset(rx_data)) begin
                        space_next = 1'b0;
                        left_next  = 1'b0;
                        right_next = 1'b0;
                    end
                end
                ST_EXT: begin
                    state_next = ST_IDLE;
                    if (rx_data == SC_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (rx_data == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_data == LEFT_CODE) begin
                        left_next = 1'b1;
                    end else if (rx_data == RIGHT_CODE) begin
                        right_next = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    if (rx_data == SPACE_CODE) begin
                        space_next = 1'b0;
                    end else if (rx_data == SC_EXT) begin
                        state_next = ST_EXT;
                    end
                end
                ST_EXT_BRK: begin
                    state_next = ST_IDLE;
                    if (rx_data == LEFT_CODE) begin
                        left_next = 1'b0;
                    end else if (rx_data == RIGHT_CODE) begin
                        right_next = 1'b0;
                    end else if (rx_data == SC_EXT) begin
                        state_next = ST_EXT;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (tmo_expire) begin
            state_next = ST_IDLE;
        end
    end

`ifdef KEY_LR_LAST_WINS_EN
    logic right_newer, right_newer_next;

    always_comb begin
        right_newer_next = right_newer;
        if (right_next && !held_right) begin
            right_newer_next = 1'b1;
        end else if (left_next && !held_left) begin
            right_newer_next = 1'b0;
        end
        vis_left  = left_next  && !(right_next && right_newer_next);
        vis_right = right_next && !(left_next && !right_newer_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            right_newer <= 1'b0;
        end else begin
            right_newer <= right_newer_next;
        end
    end
`else
    assign vis_left  = left_next;
    assign vis_right = right_next;
`endif

    assign event_next = ({space_next, vis_left, vis_right} != {key_space, key_left, key_right});

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            held_space <= 1'b0;
            held_left  <= 1'b0;
            held_right <= 1'b0;
            key_space  <= 1'b0;
            key_left   <= 1'b0;
            key_right  <= 1'b0;
            key_event  <= 1'b0;
        end else begin
            state      <= state_next;
            held_space <= space_next;
            held_left  <= left_next;
            held_right <= right_next;
            key_space  <= space_next;
            key_left   <= vis_left;
            key_right  <= vis_right;
            key_event  <= event_next;
        end
    end

endmodule

// File: tb/tb_key_state_decoder.sv
// Scoreboard bench for key_state_decoder; honours KEY_LR_LAST_WINS_EN in its reference model.
module tb_key_state_decoder;
    import kbd_pkg::*;

    localparam int unsigned TO_US = 5;
    localparam int          LIMIT = 100 * TO_US;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       key_space, key_left, key_right, key_event;

    key_state_decoder #(
        .CLK_FREQ          (100_000_000),
        .PREFIX_TIMEOUT_US (TO_US)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .key_space (key_space),
        .key_left  (key_left),
        .key_right (key_right),
        .key_event (key_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   sent = 0;
    int   seen = 0;

    kbd_state_t m_state = ST_IDLE;
    logic       m_sp = 0, m_l = 0, m_r = 0, m_newer = 0;
    logic [2:0] m_out = 3'b000;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_vis();
        logic l, r;
`ifdef KEY_LR_LAST_WINS_EN
        l = m_l && !(m_r && m_newer);
        r = m_r && !(m_l && !m_newer);
`else
        l = m_l;
        r = m_r;
`endif
        return {m_sp, l, r};
    endfunction

    task automatic model_byte(input logic [7:0] b);
        kbd_state_t s;
        s = m_state;
        m_state = ST_IDLE;
        case (s)
            ST_IDLE: begin
                if (b == SC_EXT) m_state = ST_EXT;
                else if (b == SC_BRK) m_state = ST_BRK;
                else if (b == SC_SPACE) m_sp = 1;
                else if (b == SC_BAT_OK || b == SC_BAT_ERR) begin
                    m_sp = 0; m_l = 0; m_r = 0;
                end
            end
            ST_EXT: begin
                if (b == SC_BRK) m_state = ST_EXT_BRK;
                else if (b == SC_EXT) m_state = ST_EXT;
                else if (b == SC_LEFT && !m_l) begin m_l = 1; m_newer = 0; end
                else if (b == SC_RIGHT && !m_r) begin m_r = 1; m_newer = 1; end
            end
            ST_BRK: begin
                if (b == SC_SPACE) m_sp = 0;
                else if (b == SC_EXT) m_state = ST_EXT;
            end
            default: begin
                if (b == SC_LEFT) m_l = 0;
                else if (b == SC_RIGHT) m_r = 0;
                else if (b == SC_EXT) m_state = ST_EXT;
            end
        endcase
    endtask

    task automatic push_exp(input string tag);
        logic [2:0] v;
        exp_t e;
        v = model_vis();
        e.tag = tag;
        e.val = {v, v != m_out};
        m_out = v;
        sb.push_back(e);
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic err = 1'b0);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1; rx_err = err;
        if (err) m_state = ST_IDLE;
        else model_byte(b);
        push_exp(tag);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_err = 1'b0;
        sent++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        if (m_state != ST_IDLE && n + 1 >= LIMIT) m_state = ST_IDLE;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        m_state = ST_IDLE; m_sp = 0; m_l = 0; m_r = 0; m_newer = 0; m_out = 3'b000;
        e.tag = tag; e.val = 4'b0000;
        sb.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;
        sent++;
    endtask

    always @(negedge clk) begin
        if (seen < sent) begin
            exp_t e;
            if (sb.size() == 0) begin
                check_vec("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_vec(e.tag, {28'd0, key_space, key_left, key_right, key_event}, {28'd0, e.val});
            end
            seen++;
        end
    end

    initial begin
        do_reset("reset");

        send("sp_make", 8'h29);
        send("sp_f0", 8'hF0);
        send("sp_break", 8'h29);

        send("l_e0", 8'hE0);  send("l_make", 8'h6B);
        send("r_e0", 8'hE0);  send("r_make", 8'h74);
        send("lrel_e0", 8'hE0); send("lrel_f0", 8'hF0); send("lrel", 8'h6B);
        send("rrel_e0", 8'hE0); send("rrel_f0", 8'hF0); send("rrel", 8'h74);

        send("to_e0", 8'hE0); idle(LIMIT + 1); send("to_6b", 8'h6B);
        send("nto_e0", 8'hE0); idle(LIMIT - 3); send("nto_6b", 8'h6B);
        send("ntorel_e0", 8'hE0); send("ntorel_f0", 8'hF0); send("ntorel", 8'h6B);

        send("rep1", 8'h29); send("rep2", 8'h29); send("rep3", 8'h29);
        send("bat_r_e0", 8'hE0); send("bat_r", 8'h74);
        send("bat_aa", 8'hAA);
        send("fc_sp", 8'h29); send("bat_fc", 8'hFC);

        send("err_f0", 8'hF0, 1'b1); send("err_sp", 8'h29);
        send("sprel_f0", 8'hF0); send("sprel", 8'h29);
        send("errx_e0", 8'hE0); send("errx", 8'h00, 1'b1); send("errx_6b", 8'h6B);

        send("rstm_e0", 8'hE0); send("rstm_f0", 8'hF0); do_reset("rst_mid"); send("rstm_6b", 8'h6B);
        send("rste_e0", 8'hE0); do_reset("rst_ext"); send("rste_6b", 8'h6B);

        send("fake_e0", 8'hE0); send("fake_12", 8'h12); send("fake_6b", 8'h6B);
        send("ee_e0a", 8'hE0); send("ee_e0b", 8'hE0); send("ee_6b", 8'h6B);
        send("brk_f0", 8'hF0); send("brk_e0", 8'hE0); send("brk_f0b", 8'hF0); send("brk_6b", 8'h6B);
        send("xb_e0", 8'hE0); send("xb_f0", 8'hF0); send("xb_e0b", 8'hE0); send("xb_74", 8'h74);
        send("xbrel_e0", 8'hE0); send("xbrel_f0", 8'hF0); send("xbrel", 8'h74);
        send("bo_f0", 8'hF0); send("bo_12", 8'h12); send("bo_29", 8'h29);
        send("borel_f0", 8'hF0); send("borel", 8'h29);

        send("lw_le0", 8'hE0); send("lw_l", 8'h6B);
        send("lw_re0", 8'hE0); send("lw_r", 8'h74);
        send("lw_rre0", 8'hE0); send("lw_rrf0", 8'hF0); send("lw_rrel", 8'h74);
        send("lw_r2e0", 8'hE0); send("lw_r2", 8'h74);
        send("lw_lre0", 8'hE0); send("lw_lrf0", 8'hF0); send("lw_lrel", 8'h6B);
        send("lw_rfe0", 8'hE0); send("lw_rff0", 8'hF0); send("lw_rfin", 8'h74);

        repeat (4) @(posedge clk);
        check_vec("sb_drain", 32'(sent - seen), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
